// File: rtl/cache_32x4_mem.sv
// Line-organised single-port synchronous memory: 128-bit lines of 4 x 32-bit words, byte-strobed writes.
// Optional macro CACHE_32X4_RANGE_CHECK_EN enables out-of-range detection; otherwise addresses alias.
module cache_32x4_mem #(
  parameter logic [31:0] base_addresse = 32'h0001_0000,
  parameter int          size          = 2048,
  parameter int          xlen          = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            r_v,
  input  logic            w_v,
  input  logic [xlen-1:0] adr,
  input  logic [xlen-1:0] data,
  input  logic [3:0]      strobe,
  output logic [xlen-1:0] resp,
  output logic            resp_valid
);

  localparam int line_bits = $clog2(size);
`ifdef CACHE_32X4_RANGE_CHECK_EN
  localparam logic [31:0] span = 32'(16 * size);
`endif

  logic [127:0] mem [size-1:0];

  logic [31:0]          off_s;
  logic [line_bits-1:0] line_s;
  logic [1:0]           word_s;
  logic                 in_range_s;
  logic                 wr_en_s;
  logic [31:0]          rd_word_s;

  // Keep bytes whose strobe bit is clear, take new bytes where it is set.
  function automatic logic [31:0] merge_word(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old_word;
    for (int k = 0; k < 4; k++) begin
      if (strb[k]) begin
        merged[8*k +: 8] = new_word[8*k +: 8];
      end else begin
        merged[8*k +: 8] = old_word[8*k +: 8];
      end
    end
    return merged;
  endfunction

  // Address decode; shifts over the full offset give modulo-capacity aliasing.
  always_comb begin
    off_s  = adr - base_addresse;
    word_s = 2'(off_s >> 2);
    line_s = line_bits'(off_s >> 4);
`ifdef CACHE_32X4_RANGE_CHECK_EN
    in_range_s = (off_s < span);
`else
    in_range_s = 1'b1;
`endif
    // A write wins over a simultaneous read; requests during reset are dropped.
    wr_en_s   = rst_n & w_v & in_range_s;
    rd_word_s = mem[line_s][{word_s, 5'b00000} +: 32];
  end

  // Storage array: never reset so preloaded images survive.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem[line_s][{word_s, 5'b00000} +: 32] <= merge_word(rd_word_s, data, strobe);
    end
  end

  // Response register: one-cycle read latency, write acknowledge keeps resp.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp       <= 32'h0000_0000;
      resp_valid <= 1'b0;
    end else if (w_v) begin
      resp_valid <= 1'b1;
    end else if (r_v) begin
      resp_valid <= 1'b1;
      resp       <= in_range_s ? rd_word_s : 32'h0000_0000;
    end else begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cache_32x4_mem.sv
// Self-checking bench for cache_32x4_mem: word-array reference model plus directed literal checks.
module tb_cache_32x4_mem;

  localparam logic [31:0] BASE       = 32'h0001_0000;
  localparam logic [31:0] SPAN_BYTES = 32'h0000_8000;

  logic        clk = 1'b0;
  logic        rst_n, r_v, w_v;
  logic [31:0] adr, data, resp;
  logic [3:0]  strobe;
  logic        resp_valid;

  int errors = 0;
  int checks = 0;

  cache_32x4_mem dut (
    .clk(clk), .rst_n(rst_n), .r_v(r_v), .w_v(w_v), .adr(adr),
    .data(data), .strobe(strobe), .resp(resp), .resp_valid(resp_valid)
  );

  always #5 clk = ~clk;

  // Reference: flat array of 32-bit words, byte address -> word index.
  logic [31:0] ref_mem [0:8191];
  bit          known   [0:8191];
  logic [31:0] exp_resp;
  logic        exp_valid;
  bit          exp_known;
  bit          model_ready = 1'b0;

  function automatic bit addr_ok(input logic [31:0] a);
`ifdef CACHE_32X4_RANGE_CHECK_EN
    return (a - BASE) < SPAN_BYTES;
`else
    return 1'b1;
`endif
  endfunction

  function automatic int word_index(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'((off % SPAN_BYTES) / 32'd4);
  endfunction

  always @(posedge clk) begin
    int idx;
    idx = word_index(adr);
    if (!rst_n) begin
      exp_valid <= 1'b0;
      exp_resp  <= 32'h0;
      exp_known <= 1'b1;
    end else if (w_v) begin
      exp_valid <= 1'b1;
      if (addr_ok(adr)) begin
        for (int k = 0; k < 4; k++)
          if (strobe[k]) ref_mem[idx][8*k +: 8] <= data[8*k +: 8];
        if (strobe != 4'b0000) known[idx] <= 1'b1;
      end
    end else if (r_v) begin
      exp_valid <= 1'b1;
      if (addr_ok(adr)) begin
        exp_resp  <= ref_mem[idx];
        exp_known <= known[idx];
      end else begin
        exp_resp  <= 32'h0;
        exp_known <= 1'b1;
      end
    end else begin
      exp_valid <= 1'b0;
    end
    model_ready <= 1'b1;
  end

  always @(negedge clk) begin
    if (model_ready) begin
      checks++;
      if (resp_valid !== exp_valid) begin
        errors++;
        $display("FAIL model_valid t=%0t: got %0b, want %0b", $time, resp_valid, exp_valid);
      end
      if (exp_known) begin
        checks++;
        if (resp !== exp_resp) begin
          errors++;
          $display("FAIL model_resp t=%0t: got %h, want %h", $time, resp, exp_resp);
        end
      end
    end
  end

  task automatic drive(input logic rv, input logic wv, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    r_v = rv; w_v = wv; adr = a; data = d; strobe = s;
  endtask

  task automatic check_lit(input string name, input logic v, input logic [31:0] r);
    @(posedge clk);
    #1;
    checks++;
    if (resp_valid !== v || resp !== r) begin
      errors++;
      $display("FAIL %s: got valid=%0b resp=%h, want valid=%0b resp=%h", name, resp_valid, resp, v, r);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] oor_exp;
    logic [31:0] alias_exp;
    for (int i = 0; i < 8192; i++) known[i] = 1'b0;
    rst_n = 1'b0; r_v = 1'b0; w_v = 1'b0; adr = 32'h0; data = 32'h0; strobe = 4'h0;
    @(posedge clk);
    check_lit("reset", 1'b0, 32'h0);

    // Preload line 0 through the write port.
    @(negedge clk); rst_n = 1'b1;
    r_v = 1'b0; w_v = 1'b1; adr = 32'h10000; data = 32'h11111111; strobe = 4'hF;
    drive(1'b0, 1'b1, 32'h10004, 32'h22222222, 4'hF);
    drive(1'b0, 1'b1, 32'h10008, 32'h33333333, 4'hF);
    drive(1'b0, 1'b1, 32'h1000C, 32'h44444444, 4'hF);

    // Reset with a write pending: the write must be dropped, memory kept.
    @(negedge clk); rst_n = 1'b0;
    r_v = 1'b0; w_v = 1'b1; adr = 32'h10000; data = 32'hDEADBEEF; strobe = 4'hF;
    @(posedge clk);
    check_lit("reset_hold", 1'b0, 32'h0);

    @(negedge clk); rst_n = 1'b1;
    r_v = 1'b1; w_v = 1'b0; adr = 32'h1000C; data = 32'h0; strobe = 4'h0;
    check_lit("read_word3", 1'b1, 32'h44444444);

    drive(1'b1, 1'b0, 32'h10000, 32'h0, 4'h0); check_lit("stream0", 1'b1, 32'h11111111);
    drive(1'b1, 1'b0, 32'h10004, 32'h0, 4'h0); check_lit("stream1", 1'b1, 32'h22222222);
    drive(1'b1, 1'b0, 32'h10008, 32'h0, 4'h0); check_lit("stream2", 1'b1, 32'h33333333);

    drive(1'b0, 1'b1, 32'h10004, 32'hAABBCCDD, 4'b0101); check_lit("byte_wr_ack", 1'b1, 32'h33333333);
    drive(1'b1, 1'b0, 32'h10004, 32'h0, 4'h0);           check_lit("byte_wr_read", 1'b1, 32'h22BB22DD);

    drive(1'b1, 1'b1, 32'h10010, 32'hCAFEF00D, 4'hF);    check_lit("rw_ack", 1'b1, 32'h22BB22DD);
    drive(1'b0, 1'b0, 32'h10010, 32'h0, 4'h0);           check_lit("idle", 1'b0, 32'h22BB22DD);
    drive(1'b1, 1'b0, 32'h10010, 32'h0, 4'h0);           check_lit("rw_read", 1'b1, 32'hCAFEF00D);

    drive(1'b0, 1'b1, 32'h10010, 32'h12345678, 4'h0);    check_lit("noop_wr_ack", 1'b1, 32'hCAFEF00D);
    drive(1'b1, 1'b0, 32'h10010, 32'h0, 4'h0);           check_lit("noop_wr_read", 1'b1, 32'hCAFEF00D);

`ifdef CACHE_32X4_RANGE_CHECK_EN
    oor_exp   = 32'h00000000;
    alias_exp = 32'h11111111;
`else
    oor_exp   = 32'h11111111;
    alias_exp = 32'h5A5A5A5A;
`endif
    drive(1'b1, 1'b0, 32'h00000000, 32'h0, 4'h0);        check_lit("oor_read", 1'b1, oor_exp);
    drive(1'b0, 1'b1, 32'h00000000, 32'h5A5A5A5A, 4'hF); check_lit("oor_wr_ack", 1'b1, oor_exp);
    drive(1'b1, 1'b0, 32'h10000, 32'h0, 4'h0);           check_lit("oor_wr_effect", 1'b1, alias_exp);

    drive(1'b0, 1'b1, 32'h17FFC, 32'h0BADCAFE, 4'hF);    check_lit("top_wr_ack", 1'b1, alias_exp);
    drive(1'b1, 1'b0, 32'h17FFC, 32'h0, 4'h0);           check_lit("top_read", 1'b1, 32'h0BADCAFE);
`ifdef CACHE_32X4_RANGE_CHECK_EN
    drive(1'b1, 1'b0, 32'h18000, 32'h0, 4'h0);           check_lit("past_top_read", 1'b1, 32'h00000000);
`else
    drive(1'b1, 1'b0, 32'h18000, 32'h0, 4'h0);           check_lit("past_top_read", 1'b1, 32'h5A5A5A5A);
`endif

    // Reset right after a read: the pending response is discarded.
    drive(1'b1, 1'b0, 32'h1000C, 32'h0, 4'h0);           check_lit("pre_reset_read", 1'b1, 32'h44444444);
    @(negedge clk); rst_n = 1'b0; r_v = 1'b1; w_v = 1'b0; adr = 32'h10008;
    check_lit("midstream_reset", 1'b0, 32'h0);
    @(negedge clk); rst_n = 1'b1; r_v = 1'b0;
    drive(1'b1, 1'b0, 32'h10008, 32'h0, 4'h0);           check_lit("post_reset_read", 1'b1, 32'h33333333);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
